wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/pipeline_pkg.sv | 10 +
 rtl/wb_scoreboard.sv | 21 ++
 rtl/wb_arbiter.sv | 99 +++++++++
 tb/tb_wb_arbiter.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// pipeline_pkg: writeback types, arbiter states and starvation default shared by the writeback arbiter
package pipeline_pkg;
  localparam int STARVE_LIMIT_DEFAULT = 4;
  typedef struct packed {
    logic        wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
  } writeback_t;
  typedef enum logic [1:0] {IDLE, HOLD, FORCE} wb_arb_state_t;
endpackage

// File: rtl/wb_scoreboard.sv
// wb_scoreboard: per-register pending-MDU-write mask, set on issue, cleared on retire, set wins
module wb_scoreboard (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_set_en,
  input  logic [4:0]  i_set_rd,
  input  logic        i_clr_en,
  input  logic [4:0]  i_clr_rd,
  output logic [31:0] o_mask
);
  logic [31:0] mask_q, mask_d, set_m, clr_m;
  always_comb begin
    set_m = i_set_en ? (32'd1 << i_set_rd) : 32'd0;
    clr_m = i_clr_en ? (32'd1 << i_clr_rd) : 32'd0;
    mask_d = ((mask_q & ~clr_m) | set_m) & ~32'd1;
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) mask_q <= '0;
    else mask_q <= mask_d;
  assign o_mask = mask_q;
endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: merges buffered MDU results into the pipeline writeback port; WB_STARVE_GUARD_EN adds the starvation-forced grant
module wb_arbiter
  import pipeline_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  writeback_t  i_pipe_wb_pkg,
  output logic        o_pipe_stall,
  input  logic        i_mdu_issue,
  input  logic [4:0]  i_mdu_issue_rd,
  input  logic        i_mdu_valid,
  input  logic [4:0]  i_mdu_rd_addr,
  input  logic [31:0] i_mdu_rd_data,
  output logic        o_mdu_ready,
  output writeback_t  o_wb_pkg,
  output logic [31:0] o_busy_mask
);
  wb_arb_state_t state_q, state_d;
  logic [4:0]    buf_rd_q, buf_rd_d;
  logic [31:0]   buf_data_q, buf_data_d;
  logic          clr_en, pipe_wr, hit;
  writeback_t    buf_wb;
`ifdef WB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = (cnt_q == CW'(STARVE_LIMIT)) ? cnt_q : cnt_q + 1'b1;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
`endif
  assign pipe_wr = i_pipe_wb_pkg.wren && (i_pipe_wb_pkg.rd_addr != 5'd0);
  assign hit = i_pipe_wb_pkg.rd_addr == buf_rd_q;
  assign buf_wb = '{1'b1, buf_rd_q, buf_data_q};
  assign o_mdu_ready = state_q == IDLE;
  always_comb begin
    state_d = state_q;
    buf_rd_d = buf_rd_q;
    buf_data_d = buf_data_q;
    clr_en = 1'b0;
    o_wb_pkg = i_pipe_wb_pkg;
    o_pipe_stall = 1'b0;
`ifdef WB_STARVE_GUARD_EN
    cnt_d = cnt_q;
`endif
    case (state_q)
      IDLE:
        if (i_mdu_valid && i_mdu_rd_addr != 5'd0) begin
          state_d = HOLD;
          buf_rd_d = i_mdu_rd_addr;
          buf_data_d = i_mdu_rd_data;
        end
      // a same-rd pipeline write is younger, so the buffered result is simply dropped
      HOLD:
        if (!pipe_wr || hit) begin
          o_wb_pkg = pipe_wr ? i_pipe_wb_pkg : buf_wb;
          state_d = IDLE;
          clr_en = 1'b1;
`ifdef WB_STARVE_GUARD_EN
          cnt_d = '0;
`endif
        end
`ifdef WB_STARVE_GUARD_EN
        else begin
          cnt_d = cnt_inc;
          state_d = (cnt_inc == CW'(STARVE_LIMIT)) ? FORCE : HOLD;
        end
      FORCE: begin
        o_wb_pkg = buf_wb;
        o_pipe_stall = 1'b1;
        state_d = IDLE;
        clr_en = 1'b1;
        cnt_d = '0;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      state_q <= IDLE;
      buf_rd_q <= '0;
      buf_data_q <= '0;
    end else begin
      state_q <= state_d;
      buf_rd_q <= buf_rd_d;
      buf_data_q <= buf_data_d;
    end
  wb_scoreboard u_sb (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_set_en (i_mdu_issue),
    .i_set_rd (i_mdu_issue_rd),
    .i_clr_en (clr_en),
    .i_clr_rd (buf_rd_q),
    .o_mask   (o_busy_mask)
  );
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: randomized and directed scoreboard bench against a transaction-level writeback model
module tb_wb_arbiter;
  import pipeline_pkg::*;
  localparam int LIMIT = 4;
`ifdef WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  writeback_t pipe = '0, wb;
  logic mdu_issue = 1'b0, mdu_valid = 1'b0, stall, ready;
  logic [4:0] issue_rd = '0, mdu_rd = '0;
  logic [31:0] mdu_data = '0, mask;
  always #5 clk = ~clk;
  wb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst), .i_pipe_wb_pkg(pipe), .o_pipe_stall(stall),
    .i_mdu_issue(mdu_issue), .i_mdu_issue_rd(issue_rd), .i_mdu_valid(mdu_valid),
    .i_mdu_rd_addr(mdu_rd), .i_mdu_rd_data(mdu_data), .o_mdu_ready(ready),
    .o_wb_pkg(wb), .o_busy_mask(mask)
  );
  typedef struct packed {
    writeback_t wb;
    logic stall;
    logic ready;
    logic [31:0] mask;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0;
  bit pend = 0, forced = 0;
  logic [4:0] p_rd = '0;
  logic [31:0] p_data = '0;
  int lost = 0;
  logic [31:0] busy = '0;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", n, a, x, $time);
    end
  endtask
  // one cycle: drive after the edge, predict this cycle's outputs, advance the model
  task automatic cyc(input bit r, input bit pw, input logic [4:0] pr, input logic [31:0] pd,
                     input bit v, input logic [4:0] mr, input logic [31:0] md,
                     input bit iss, input logic [4:0] ird);
    exp_t e;
    bit retire;
    @(posedge clk);
    #1;
    rst = r;
    pipe = '{pw, pr, pd};
    mdu_valid = v; mdu_rd = mr; mdu_data = md;
    mdu_issue = iss; issue_rd = ird;
    retire = 0;
    if (r) begin
      pend = 0; forced = 0; lost = 0; busy = '0;
      e = '{pipe, 1'b0, 1'b1, 32'd0};
    end else begin
      e = '{pipe, 1'b0, !pend, busy};
      if (pend) begin
        if (forced) begin
          e.wb = '{1'b1, p_rd, p_data};
          e.stall = 1'b1;
          retire = 1;
        end else if (!(pw && pr != 0)) begin
          e.wb = '{1'b1, p_rd, p_data};
          retire = 1;
        end else if (pr == p_rd) retire = 1;
        else begin
          lost = (lost < LIMIT) ? lost + 1 : LIMIT;
          if (GUARD && lost == LIMIT) forced = 1;
        end
      end
      if (retire) begin
        busy[p_rd] = 1'b0;
        pend = 0; forced = 0; lost = 0;
      end else if (!pend && v && mr != 0) begin
        pend = 1; p_rd = mr; p_data = md;
      end
      if (iss && ird != 0) busy[ird] = 1'b1;
    end
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  always @(negedge clk) begin : mon
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("wb_pkg", 64'(wb), 64'(e.wb));
      chk("pipe_stall", 64'(stall), 64'(e.stall));
      chk("mdu_ready", 64'(ready), 64'(e.ready));
      chk("busy_mask", 64'(mask), 64'(e.mask));
    end
  end
  initial begin
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 3, 32'h5, 0, 0, 0, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(0, 1, 5, 32'h11, 1, 7, 32'h22, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(0, 1, 5, 32'h11, 1, 7, 32'h22, 0, 0);
    for (int i = 0; i < 20; i++) cyc(0, 1, 5'(3 + i % 3), $urandom, 0, 0, 0, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cyc(0, 0, 0, 0, 1, 9, 32'h99, 0, 0);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
    cyc(0, 0, 0, 0, 1, 9, 32'h98, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 9);
    idle(3);
    cyc(0, 0, 0, 0, 1, 9, 32'h97, 0, 0);
    idle(2);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 1, 7, 32'h44, 0, 0);
    cyc(0, 1, 7, 32'h33, 0, 0, 0, 0, 0);
    idle(4);
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 7);
    cyc(0, 0, 0, 0, 1, 7, 32'h55, 0, 0);
    cyc(1, 1, 2, 32'h66, 0, 0, 0, 0, 0);
    idle(4);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(99) == 0, $urandom_range(9) < 7, 5'($urandom_range(15)), $urandom,
          $urandom_range(9) < 4, 5'($urandom_range(15)), $urandom,
          $urandom_range(9) < 3, 5'($urandom_range(15)));
    idle(2);
    @(negedge clk);
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
